cva6_hpdcache_store_amo_seq: RTL and testbench

Store/AMO sequencer between the CVA6 store unit / AMO path and the HPDcache store/AMO interface adapter. Buffers granted stores in a small FIFO so the store unit is decoupled from cache back-pressure. Serialises AMOs behind all older buffered stores. Guarantees the adapter never sees a store and an AMO request in the same cycle.

---
 rtl/cva6_hpdcache_seq_pkg.sv | 67 ++++++
 rtl/cva6_hpdcache_st_fifo.sv | 54 +++++
 rtl/cva6_hpdcache_store_amo_seq.sv | 102 ++++++++++
 tb/tb_cva6_hpdcache_store_amo_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_hpdcache_seq_pkg.sv
// Types shared by the store/AMO sequencer: the dcache request/response and AMO
// structs this slice exchanges with the core and adapter, the FIFO entry and FSM states.
package cva6_hpdcache_seq_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;
  localparam int unsigned DCACHE_DATA_WIDTH  = 64;
  localparam int unsigned DCACHE_BE_WIDTH    = DCACHE_DATA_WIDTH / 8;
  localparam int unsigned DCACHE_TID_WIDTH   = 2;

  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64};

  typedef enum logic [3:0] {
    AMO_NONE = 4'd0, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND,
    AMO_OR, AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU
  } amo_t;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [DCACHE_DATA_WIDTH-1:0]  data_wdata;
    logic                          data_req;
    logic [DCACHE_BE_WIDTH-1:0]    data_be;
    logic [1:0]                    data_size;
    logic [DCACHE_TID_WIDTH-1:0]   data_id;
    logic                          kill_req;
  } dcache_req_i_t;

  typedef struct packed {
    logic                         data_gnt;
    logic                         data_rvalid;
    logic [DCACHE_TID_WIDTH-1:0]  data_rid;
    logic [DCACHE_DATA_WIDTH-1:0] data_rdata;
  } dcache_req_o_t;

  typedef struct packed {
    logic                         req;
    amo_t                         amo_op;
    logic [1:0]                   size;
    logic [DCACHE_DATA_WIDTH-1:0] operand_a;
    logic [DCACHE_DATA_WIDTH-1:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic                         ack;
    logic [DCACHE_DATA_WIDTH-1:0] result;
  } amo_resp_t;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] index;
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic [DCACHE_DATA_WIDTH-1:0]  wdata;
    logic [DCACHE_BE_WIDTH-1:0]    be;
    logic [1:0]                    size;
  } st_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    AMO   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/cva6_hpdcache_st_fifo.sv
// Store buffer: DEPTH-entry FIFO of st_entry_t with registered head, no fall-through.
module cva6_hpdcache_st_fifo
  import cva6_hpdcache_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  st_entry_t                entry_i,
  input  logic                     pop_i,
  output st_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  st_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Payload is only observed when count says it is valid, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= entry_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cva6_hpdcache_store_amo_seq.sv
// Store/AMO sequencer: buffers stores, drains them ahead of an AMO and keeps the
// adapter's store and AMO request channels mutually exclusive.
module cva6_hpdcache_store_amo_seq
  import cva6_hpdcache_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  dcache_req_i_t st_req_i,
  output dcache_req_o_t st_req_o,
  input  amo_req_t      amo_req_i,
  output amo_resp_t     amo_resp_o,
  output dcache_req_i_t adp_req_o,
  input  dcache_req_o_t adp_req_i,
  output amo_req_t      adp_amo_req_o,
  input  amo_resp_t     adp_amo_resp_i,
  output logic          empty_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (CVA6Cfg.XLEN != DCACHE_DATA_WIDTH) begin : g_cfg_chk
    $error("CVA6Cfg.XLEN must match DCACHE_DATA_WIDTH");
  end

  seq_state_e      state_q, state_d;
  st_entry_t       push_entry, head;
  logic            push, pop, full, fifo_empty, store_vld, drain_done;
  logic [CW-1:0]   count;
  logic            unused_st;

  assign unused_st = ^{st_req_i.data_id, st_req_i.kill_req};

  // Holding off stores while an AMO is requested keeps it from being overtaken.
  assign push = rst_ni & st_req_i.data_req & ~full & (state_q == IDLE) & ~amo_req_i.req;
  assign store_vld  = ~fifo_empty & (state_q != AMO);
  assign pop        = store_vld & adp_req_i.data_gnt;
  // True when the buffer is empty after this cycle, so the AMO can go out next cycle.
  assign drain_done = fifo_empty | ((count == CW'(1)) & pop);

  assign push_entry = '{index: st_req_i.address_index, tag: st_req_i.address_tag,
                        wdata: st_req_i.data_wdata, be: st_req_i.data_be,
                        size: st_req_i.data_size};

  cva6_hpdcache_st_fifo #(.DEPTH(DEPTH)) i_st_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (amo_req_i.req) state_d = drain_done ? AMO : DRAIN;
      DRAIN:   if (!amo_req_i.req) state_d = IDLE;
               else if (drain_done) state_d = AMO;
      AMO:     if (adp_amo_resp_i.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    st_req_o      = '0;
    adp_req_o     = '0;
    adp_amo_req_o = '0;
    amo_resp_o    = '0;
    st_req_o.data_gnt = push;
    if (rst_ni) begin
      st_req_o.data_rvalid = adp_req_i.data_rvalid;
      st_req_o.data_rid    = adp_req_i.data_rid;
      st_req_o.data_rdata  = adp_req_i.data_rdata;
    end
    if (store_vld) begin
      adp_req_o.data_req      = 1'b1;
      adp_req_o.address_index = head.index;
      adp_req_o.address_tag   = head.tag;
      adp_req_o.data_wdata    = head.wdata;
      adp_req_o.data_be       = head.be;
      adp_req_o.data_size     = head.size;
    end
    if (state_q == AMO) begin
      adp_amo_req_o = amo_req_i;
      amo_resp_o    = adp_amo_resp_i;
    end
  end

  assign empty_o = fifo_empty & (state_q == IDLE);

endmodule

// File: tb/tb_cva6_hpdcache_store_amo_seq.sv
// Bench for the store/AMO sequencer: queue-based reference model plus directed and random traffic.
module tb_cva6_hpdcache_store_amo_seq;
  import cva6_hpdcache_seq_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_req_i_t st_req, adp_req;
  dcache_req_o_t st_rsp, adp_rsp;
  amo_req_t      amo_req, adp_amo_req;
  amo_resp_t     amo_rsp, adp_amo_rsp;
  logic          empty;

  cva6_hpdcache_store_amo_seq #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .st_req_i(st_req), .st_req_o(st_rsp),
    .amo_req_i(amo_req), .amo_resp_o(amo_rsp),
    .adp_req_o(adp_req), .adp_req_i(adp_rsp),
    .adp_amo_req_o(adp_amo_req), .adp_amo_resp_i(adp_amo_rsp),
    .empty_o(empty)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: in-order store queue plus an outstanding-AMO flag
  st_entry_t   mq[$];
  bit          amo_out = 0;
  int          n_push = 0, n_pop = 0;
  logic [11:0] pop_idx[$];

  always @(negedge clk) begin : mon
    bit eg, ea, hp;
    st_entry_t e;
    if (!rst_n) begin
      mq.delete();
      amo_out = 0;
    end else begin
      hp = mq.size() > 0;
      eg = st_req.data_req && mq.size() < DEPTH && !amo_out && !amo_req.req;
      ea = amo_out && mq.size() == 0;
      chk("st_gnt", 64'(st_rsp.data_gnt), 64'(eg));
      chk("adp_req", 64'(adp_req.data_req), 64'(hp));
      if (hp && adp_req.data_req) begin
        chk("adp_addr", 64'({adp_req.address_tag, adp_req.address_index}), 64'({mq[0].tag, mq[0].index}));
        chk("adp_wdata", adp_req.data_wdata, mq[0].wdata);
        chk("adp_besz", 64'({adp_req.data_be, adp_req.data_size}), 64'({mq[0].be, mq[0].size}));
        chk("adp_kill_id", 64'({adp_req.kill_req, adp_req.data_id}), 64'(0));
      end
      chk("amo_req", 64'(adp_amo_req.req), 64'(ea));
      if (ea) chk("amo_opa", adp_amo_req.operand_a, amo_req.operand_a);
      chk("amo_ack", 64'(amo_rsp.ack), 64'(ea && adp_amo_rsp.ack));
      if (ea && adp_amo_rsp.ack) chk("amo_res", amo_rsp.result, adp_amo_rsp.result);
      chk("empty", 64'(empty), 64'(mq.size() == 0 && !amo_out));
      chk("mutex", 64'(adp_req.data_req & adp_amo_req.req), 64'(0));
      if (hp && adp_rsp.data_gnt) begin
        pop_idx.push_back(mq[0].index);
        void'(mq.pop_front());
        n_pop++;
      end
      if (eg) begin
        e.index = st_req.address_index; e.tag = st_req.address_tag;
        e.wdata = st_req.data_wdata; e.be = st_req.data_be; e.size = st_req.data_size;
        mq.push_back(e);
        n_push++;
      end
      if (!amo_out && amo_req.req) amo_out = 1;
      else if (ea && adp_amo_rsp.ack) amo_out = 0;
    end
  end

  // store unit: holds each request until granted
  int st_target = 0, st_issued = 0;
  bit st_rand = 0;
  initial begin : st_drv
    bit g, pend;
    pend = 0;
    st_req = '0;
    forever begin
      @(negedge clk); g = st_rsp.data_gnt;
      @(posedge clk); #1;
      if (g) pend = 0;
      if (!pend && st_issued < st_target && (!st_rand || $urandom_range(1, 0) == 1)) begin
        pend = 1;
        st_req.address_index = 12'h10 + 12'(st_issued);
        st_req.address_tag   = 44'({$urandom, $urandom});
        st_req.data_wdata    = {$urandom, $urandom};
        st_req.data_be       = 8'($urandom);
        st_req.data_size     = 2'($urandom_range(3, 0));
        st_issued++;
      end
      st_req.data_req = pend;
    end
  end

  // adapter: gnt mode 0=never, 1=always, 2=random; AMO ack after ack_delay cycles
  int gnt_mode = 1, ack_delay = 0;
  logic [63:0] ack_res = '0;
  initial begin : adp_drv
    int w;
    w = 0;
    adp_rsp = '0;
    adp_amo_rsp = '0;
    forever begin
      @(posedge clk); #1;
      case (gnt_mode)
        0:       adp_rsp.data_gnt = 1'b0;
        1:       adp_rsp.data_gnt = 1'b1;
        default: adp_rsp.data_gnt = 1'($urandom_range(1, 0));
      endcase
      if (adp_amo_req.req && rst_n) begin
        w++;
        adp_amo_rsp.ack    = (w > ack_delay);
        adp_amo_rsp.result = adp_amo_rsp.ack ? ack_res : '0;
      end else begin
        w = 0;
        adp_amo_rsp = '0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic amo_raise(input logic [63:0] opa);
    @(posedge clk); #1;
    amo_req.req = 1'b1; amo_req.amo_op = AMO_ADD; amo_req.size = 2'd3;
    amo_req.operand_a = opa; amo_req.operand_b = {$urandom, $urandom};
  endtask

  task automatic amo_wait(output int lat, output bit got, output logic [63:0] res);
    lat = -1; got = 0; res = '0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk); #1;
      if (adp_amo_req.req && lat < 0) lat = i;
      if (amo_rsp.ack) begin got = 1; res = amo_rsp.result; end
    end
    if (!got) chk("amo_timeout", 64'(0), 64'(1));
  endtask

  task automatic amo_drop();
    @(posedge clk); #1;
    amo_req.req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (mq.size() == 0 && !st_req.data_req && !amo_out);
    end
    chk(tag, 64'(ok), 64'(1));
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat, base, mx;
    bit got;
    logic [63:0] res;
    amo_req = '0;

    // reset values
    #12;
    chk("rst_st", 64'(|st_rsp), 64'(0));
    chk("rst_adp", 64'(|adp_req), 64'(0));
    chk("rst_amo", 64'(|{adp_amo_req, amo_rsp}), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    @(posedge clk); #3 rst_n = 1'b1;

    // 8 back-to-back stores, always-ready adapter
    base = pop_idx.size();
    st_target = 8;
    mx = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      if (mq.size() > mx) mx = mq.size();
    end
    chk("t1_pops", 64'(pop_idx.size() - base), 64'(8));
    for (int i = 0; i < 8; i++)
      if (base + i < pop_idx.size()) chk("t1_order", 64'(pop_idx[base + i]), 64'(12'h10 + 12'(i)));
    chk("t1_not_full", 64'(mx < DEPTH), 64'(1));

    // back-pressure: 4 grants then stall, then drain in order
    @(posedge clk); #2;
    gnt_mode = 0;
    st_target = st_issued + 100;
    base = n_push;
    repeat (12) @(posedge clk);
    #2;
    chk("t2_grants", 64'(n_push - base), 64'(4));
    @(negedge clk); #1;
    chk("t2_gnt_low", 64'(st_rsp.data_gnt), 64'(0));
    gnt_mode = 1;
    st_target = st_issued + 2;
    wait_idle("t2_drain");

    // AMO behind 3 buffered stores
    @(posedge clk); #2;
    gnt_mode = 0;
    st_target = st_issued + 3;
    repeat (8) @(posedge clk);
    #2;
    chk("t3_buf", 64'(mq.size()), 64'(3));
    base = n_pop;
    ack_delay = 5;
    ack_res = 64'h1234;
    amo_raise(64'h8000_0040);
    #1;
    gnt_mode = 1;
    st_target = st_issued + 1;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      else begin @(negedge clk); #1; end
      if (adp_amo_req.req) lat = i;
    end
    chk("t3_amo_lat", 64'(lat), 64'(4));
    chk("t3_pops_first", 64'(n_pop - base), 64'(3));
    amo_wait(lat, got, res);
    chk("t4_ack", 64'(got), 64'(1));
    chk("t4_result", res, 64'h1234);
    amo_drop();
    @(negedge clk); #1;
    chk("t4_next_gnt", 64'(st_rsp.data_gnt), 64'(1));
    wait_idle("t4_idle");

    // AMO with empty buffer issues the next cycle
    ack_delay = 0;
    ack_res = 64'hdead_beef_0000_0001;
    amo_raise(64'h1000);
    amo_wait(lat, got, res);
    chk("t5_lat", 64'(lat), 64'(1));
    chk("t5_result", res, 64'hdead_beef_0000_0001);
    amo_drop();

    // random stores / AMOs with random adapter timing
    @(posedge clk); #2;
    gnt_mode = 2;
    st_rand = 1;
    st_target = 1000000;
    while (cyc < 10000) begin
      repeat ($urandom_range(20, 0)) @(posedge clk);
      ack_delay = $urandom_range(4, 0);
      ack_res = {$urandom, $urandom};
      amo_raise({$urandom, $urandom});
      amo_wait(lat, got, res);
      amo_drop();
    end
    #2;
    st_target = st_issued;
    st_rand = 0;
    gnt_mode = 1;
    wait_idle("t6_drain");
    chk("t6_balance", 64'(n_push), 64'(n_pop));

    // reset while an AMO waits for its ack
    ack_delay = 1000;
    amo_raise(64'h40);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      got = adp_amo_req.req;
    end
    chk("t7_in_amo", 64'(got), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_st", 64'(|st_rsp), 64'(0));
    chk("t7_rst_adp", 64'(|adp_req), 64'(0));
    chk("t7_rst_amo", 64'(|{adp_amo_req, amo_rsp}), 64'(0));
    chk("t7_rst_empty", 64'(empty), 64'(1));
    amo_drop();
    @(posedge clk); #3 rst_n = 1'b1;
    st_target = st_issued + 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      got = st_rsp.data_gnt;
    end
    chk("t7_gnt_after", 64'(got), 64'(1));
    wait_idle("t7_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
